wb_trace_checker: RTL and testbench

//  Synthesizable, parametrised register-writeback checker for the openmips core.
//  - Replaces hard-coded per-cycle register asserts with a loadable table of

---
 rtl/wb_trace_checker.sv | 160 ++++++++++++++++
 tb/tb_wb_trace_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Register-writeback trace checker: compares snooped regfile writes
// against a loadable table of expected (reg, value) pairs in order.
module wb_trace_checker #(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 5,
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 64,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [PTR_W-1:0]  ld_idx,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [PTR_W:0]    exp_count,
  input  logic              start,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [PTR_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_got,
  output logic [PTR_W:0]    match_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [TW-1:0]  L_TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t              r_state, w_state;
  logic [PTR_W:0]      r_ptr, w_ptr;
  logic [PTR_W:0]      r_cnt, w_cnt;
  logic [PTR_W:0]      r_match, w_match;
  logic [TW-1:0]       r_timer, w_timer;
  logic [1:0]          r_code, w_code;
  logic [PTR_W-1:0]    r_idx, w_idx;
  logic [DATA_W-1:0]   r_got, w_got;

  logic [ADDR_W-1:0]   r_tab_a [DEPTH];
  logic [DATA_W-1:0]   r_tab_d [DEPTH];

  logic                w_valid;
  logic                w_hit;
  logic                w_start;
  logic [PTR_W:0]      w_clamp;
  logic [PTR_W:0]      w_last;
  logic [PTR_W:0]      w_inc;
  logic [PTR_W-1:0]    w_pidx;

  assign w_pidx  = r_ptr[PTR_W-1:0];
  assign w_valid = wb_we && (wb_waddr != '0);
  assign w_hit   = (r_tab_a[w_pidx] == wb_waddr)
                && (r_tab_d[w_pidx] == wb_wdata);
  assign w_start = start && (r_state != S_RUN);
  assign w_clamp = (exp_count > L_DEPTH) ? L_DEPTH : exp_count;
  assign w_last  = r_cnt - (PTR_W+1)'(1);
  assign w_inc   = r_match + (PTR_W+1)'(1);

  // Table RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_en && r_state == S_IDLE) begin
      r_tab_a[ld_idx] <= ld_addr;
      r_tab_d[ld_idx] <= ld_data;
    end
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_match = r_match;
    w_timer = r_timer;
    w_code  = r_code;
    w_idx   = r_idx;
    w_got   = r_got;
    if (w_start) begin
      w_cnt   = w_clamp;
      w_ptr   = '0;
      w_match = '0;
      w_timer = '0;
      w_code  = 2'd0;
      w_idx   = '0;
      w_got   = '0;
      w_state = (w_clamp == '0) ? S_PASS : S_RUN;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_valid && w_hit) begin
            w_match = w_inc;
            w_ptr   = r_ptr + (PTR_W+1)'(1);
            w_timer = '0;
            if (w_inc == r_cnt) w_state = S_PASS;
          end else if (w_valid) begin
            w_state = S_FAIL;
            w_code  = 2'd1;
            w_idx   = w_pidx;
            w_got   = wb_wdata;
          end else if (r_timer == L_TLAST) begin
            w_state = S_FAIL;
            w_code  = 2'd2;
            w_idx   = w_pidx;
          end else begin
            w_timer = r_timer + TW'(1);
          end
        end
        S_PASS: begin
          if (w_valid) begin
            w_state = S_FAIL;
            w_code  = 2'd3;
            w_idx   = w_last[PTR_W-1:0];
            w_got   = wb_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_match <= '0;
      r_timer <= '0;
      r_code  <= 2'd0;
      r_idx   <= '0;
      r_got   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_match <= w_match;
      r_timer <= w_timer;
      r_code  <= w_code;
      r_idx   <= w_idx;
      r_got   <= w_got;
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass      = (r_state == S_PASS);
  assign err_code  = r_code;
  assign err_idx   = r_idx;
  assign err_got   = r_got;
  assign match_cnt = r_match;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed scenarios plus randomized runs
// checked every cycle against a transaction-level reference model.
module tb_wb_trace_checker;

  localparam int TO = 64;
  localparam int DP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  exp_count;
  logic        start;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        busy, done, pass;
  logic [1:0]  err_code;
  logic [3:0]  err_idx;
  logic [31:0] err_got;
  logic [4:0]  match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 pass, 3 fail
  int          m_st;
  int          m_exp, m_ptr, m_match, m_quiet;
  int          m_code, m_idx;
  logic [31:0] m_got;
  int          m_ta [DP];
  logic [31:0] m_td [DP];

  wb_trace_checker #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(DP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .exp_count(exp_count), .start(start),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .err_idx(err_idx),
    .err_got(err_got), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", {31'b0, busy}, {31'b0, m_st == 1});
    chk("done", {31'b0, done}, {31'b0, m_st >= 2});
    chk("pass", {31'b0, pass}, {31'b0, m_st == 2});
    chk("err_code", {30'b0, err_code}, 32'(m_code));
    chk("err_idx", {28'b0, err_idx}, 32'(m_idx));
    chk("err_got", err_got, m_got);
    chk("match_cnt", {27'b0, match_cnt}, 32'(m_match));
  endtask

  task automatic m_fail(int code, int idx, logic [31:0] got);
    m_st = 3; m_code = code; m_idx = idx % DP; m_got = got;
  endtask

  task automatic model_reset();
    m_st = 0; m_exp = 0; m_ptr = 0; m_match = 0; m_quiet = 0;
    m_code = 0; m_idx = 0; m_got = '0;
  endtask

  task automatic model_step();
    int  old;
    bit  valid;
    old   = m_st;
    valid = wb_we && (wb_waddr != 0);
    if (ld_en && old == 0) begin
      m_ta[ld_idx] = ld_addr;
      m_td[ld_idx] = ld_data;
    end
    if (start && old != 1) begin
      m_exp = (exp_count > DP) ? DP : int'(exp_count);
      m_ptr = 0; m_match = 0; m_quiet = 0;
      m_code = 0; m_idx = 0; m_got = '0;
      m_st = (m_exp == 0) ? 2 : 1;
    end else if (old == 1) begin
      if (valid) begin
        if (wb_waddr == m_ta[m_ptr] && wb_wdata == m_td[m_ptr]) begin
          m_match++; m_ptr++; m_quiet = 0;
          if (m_match == m_exp) m_st = 2;
        end else m_fail(1, m_ptr, wb_wdata);
      end else begin
        m_quiet++;
        if (m_quiet == TO) m_fail(2, m_ptr, '0);
      end
    end else if (old == 2 && valid) begin
      m_fail(3, m_exp - 1, wb_wdata);
    end
  endtask

  task automatic set_idle();
    ld_en = 0; start = 0; wb_we = 0;
    wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic nop();
    set_idle(); step();
  endtask

  task automatic load(int idx, int a, logic [31:0] d);
    set_idle();
    ld_en = 1; ld_idx = 4'(idx); ld_addr = 5'(a); ld_data = d;
    step();
    ld_en = 0;
  endtask

  task automatic go(int cnt);
    set_idle();
    start = 1; exp_count = 5'(cnt);
    step();
    start = 0;
  endtask

  task automatic wr(int a, logic [31:0] d);
    set_idle();
    wb_we = 1; wb_waddr = 5'(a); wb_wdata = d;
    step();
    wb_we = 0;
  endtask

  task automatic do_reset();
    set_idle();
    #2 rst = 0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1;
    #1;
  endtask

  task automatic load_s1();
    load(0, 1, 32'h01010000);
    load(1, 1, 32'h01010101);
    load(2, 2, 32'h01011101);
    load(3, 1, 32'h01011101);
  endtask

  task automatic run_s1();
    wr(1, 32'h01010000);
    wr(1, 32'h01010101);
    wr(2, 32'h01011101);
    chk("s1_busy", {31'b0, busy}, 32'd1);
    wr(1, 32'h01011101);
  endtask

  initial begin
    int k, cnt, c, len;
    logic [31:0] d;
    rst = 0; exp_count = '0; ld_idx = '0; ld_addr = '0; ld_data = '0;
    set_idle();
    model_reset();
    foreach (m_ta[i]) begin m_ta[i] = 0; m_td[i] = '0; end
    #2 check_all();
    @(posedge clk); #1 rst = 1;

    // 1: basic pass
    load_s1(); go(4); run_s1();
    chk("s1_pass", {31'b0, pass}, 32'd1);
    chk("s1_match", {27'b0, match_cnt}, 32'd4);

    // 4: write to $0 in PASS is ignored, real write overruns
    wr(0, 32'hDEAD0000);
    chk("s4_zero", {31'b0, pass}, 32'd1);
    wr(4, 32'h0000FF00);
    chk("s4_code", {30'b0, err_code}, 32'd3);
    chk("s4_idx", {28'b0, err_idx}, 32'd3);

    // 2: mismatch on 3rd write (restart from FAIL, table kept)
    go(4);
    wr(1, 32'h01010000); wr(1, 32'h01010101); wr(2, 32'h01011100);
    chk("s2_code", {30'b0, err_code}, 32'd1);
    chk("s2_idx", {28'b0, err_idx}, 32'd2);
    chk("s2_got", err_got, 32'h01011100);
    chk("s2_match", {27'b0, match_cnt}, 32'd2);

    // 3: timeout exactly TO cycles after first match
    go(2); wr(1, 32'h01010000);
    k = 0;
    while (!done && k < 3 * TO) begin nop(); k++; end
    chk("s3_cycles", 32'(k), 32'(TO));
    chk("s3_code", {30'b0, err_code}, 32'd2);
    chk("s3_idx", {28'b0, err_idx}, 32'd1);

    // 5: gaps and $zero writes interleaved, then empty run
    go(4);
    wr(0, 32'h1); nop(); wr(1, 32'h01010000);
    wr(0, 32'h2); wr(1, 32'h01010101); nop(); nop();
    wr(2, 32'h01011101); wr(0, 32'h3); wr(1, 32'h01011101);
    chk("s5_pass", {31'b0, pass}, 32'd1);
    go(0);
    chk("s5_empty", {31'b0, pass}, 32'd1);
    chk("s5_cnt0", {27'b0, match_cnt}, 32'd0);

    // 6: async reset mid-run, reload, ld_en during RUN ignored
    go(4); wr(1, 32'h01010000);
    @(posedge clk); #3 rst = 0;
    #1 model_reset();
    chk("s6_rst_busy", {31'b0, busy}, 32'd0);
    check_all();
    @(posedge clk); #1 rst = 1;
    load_s1(); go(4);
    wr(1, 32'h01010000);
    load(2, 2, 32'hBADBAD00);
    load(3, 7, 32'h12345678);
    wr(1, 32'h01010101); wr(2, 32'h01011101); wr(1, 32'h01011101);
    chk("s6_pass", {31'b0, pass}, 32'd1);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      do_reset();
      cnt = $urandom_range(1, DP);
      if (r % 5 == 0) cnt = $urandom_range(DP + 1, 31);
      for (int i = 0; i < DP - 1; i++)
        load(i, $urandom_range(1, 31), $urandom);
      set_idle();
      ld_en = 1; ld_idx = 4'(DP - 1);
      ld_addr = 5'($urandom_range(1, 31)); ld_data = $urandom;
      start = 1; exp_count = 5'(cnt);
      step();
      k = 0;
      while (m_st == 1 && k < 400) begin
        k++;
        c = $urandom_range(0, 19);
        if (c <= 11 || (c == 17 && r % 3 != 0)) begin
          wr(m_ta[m_ptr], m_td[m_ptr]);
        end else if (c == 17) begin
          d = m_td[m_ptr] ^ (32'h1 << $urandom_range(0, 31));
          wr(m_ta[m_ptr], d);
        end else if (c <= 14) begin
          set_idle(); wb_waddr = 5'($urandom_range(1, 31));
          ld_en = 1; ld_idx = 4'(m_ptr % DP); ld_data = $urandom;
          step();
        end else if (c <= 16) begin
          wr(0, $urandom);
        end else begin
          len = $urandom_range(1, (r % 7 == 0) ? TO + 6 : 5);
          for (int j = 0; j < len && m_st == 1; j++) nop();
        end
      end
      chk("rnd_bound", 32'(m_st != 1), 32'd1);
      if (m_st == 2 && $urandom_range(0, 1) == 1)
        wr($urandom_range(0, 31), $urandom);
      nop();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
